// File: rtl/chip8_sprite_draw_pkg.sv
// chip8_pkg: shared screen geometry, framebuffer indexing and draw-engine states.
// No ports; imported by the sprite draw engine, its row XOR helper and its interface.
package chip8_pkg;
    localparam int SCR_W   = 64;
    localparam int SCR_H   = 32;
    localparam int FB_BITS = SCR_W * SCR_H;

    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FETCH, ST_DRAW, ST_DONE} state_t;

    // Row-major bit index: row*64 + col is simply the concatenation of the two fields.
    function automatic logic [10:0] fb_idx(input logic [4:0] row, input logic [5:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/chip8_sprite_draw_if.sv
// chip8_sprite_draw_if: command, memory-read and framebuffer signals of the sprite draw engine.
// Command: draw_start, clear_start, x_in, y_in, n_in, i_addr. Memory: mem_rd, mem_addr, mem_data.
// Status: busy, done, collision. Video: flat_video_memory (bit = row*64 + col).
interface chip8_sprite_draw_if #(parameter int ADDR_W = 12);
    import chip8_pkg::*;
    logic               draw_start;
    logic               clear_start;
    logic [7:0]         x_in;
    logic [7:0]         y_in;
    logic [3:0]         n_in;
    logic [ADDR_W-1:0]  i_addr;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_data;
    logic               busy;
    logic               done;
    logic               collision;
    logic [FB_BITS-1:0] flat_video_memory;

    modport master (
        output draw_start, clear_start, x_in, y_in, n_in, i_addr, mem_data,
        input  mem_rd, mem_addr, busy, done, collision, flat_video_memory
    );
    modport slave (
        input  draw_start, clear_start, x_in, y_in, n_in, i_addr, mem_data,
        output mem_rd, mem_addr, busy, done, collision, flat_video_memory
    );
endinterface

// File: rtl/chip8_sprite_row_xor.sv
// chip8_sprite_row_xor: XORs one sprite byte into a 64-pixel row with right-edge clipping.
// Ports: i_row (current row), i_byte (sprite byte, MSB leftmost), i_x0 (start column),
// o_row (updated row), o_coll (some lit pixel was turned off).
module chip8_sprite_row_xor
    import chip8_pkg::*;
(
    input  logic [SCR_W-1:0] i_row,
    input  logic [7:0]       i_byte,
    input  logic [5:0]       i_x0,
    output logic [SCR_W-1:0] o_row,
    output logic             o_coll
);
    logic [7:0]       w_rev;
    logic [SCR_W-1:0] w_mask;

    // Bit 0 of the row is the leftmost column, so the byte is reversed before shifting.
    for (genvar g = 0; g < 8; g++) begin : g_rev
        assign w_rev[g] = i_byte[7-g];
    end

    // The 64-bit shift drops pixels past column 63: clipping, no wrap.
    assign w_mask = {{(SCR_W-8){1'b0}}, w_rev} << i_x0;
    assign o_row  = i_row ^ w_mask;
    assign o_coll = |(i_row & w_mask);
endmodule

// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw: CHIP-8 framebuffer owner executing DXYN sprite draws and 00E0 clears.
// Ports: SYS_CLK, SYS_RST_N (async active-low), bus (slave side of chip8_sprite_draw_if:
// commands in, memory reads out, busy/done/collision status, flat framebuffer out).
module chip8_sprite_draw
    import chip8_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST_N,
    chip8_sprite_draw_if.slave   bus
);
    state_t             r_state;
    logic [5:0]         r_x0;
    logic [4:0]         r_y0;
    logic [3:0]         r_n;
    logic [3:0]         r_row;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_rd;
    logic               r_coll;
    logic [FB_BITS-1:0] r_fb;

    logic [4:0]         w_cur_y;
    logic [SCR_W-1:0]   w_cur_row;
    logic [SCR_W-1:0]   w_new_row;
    logic               w_row_coll;
    logic               w_last;

    // Rows are only drawn while y0+r < 32, so this 5-bit sum never wraps in DRAW.
    assign w_cur_y   = r_y0 + {1'b0, r_row};
    assign w_cur_row = r_fb[fb_idx(w_cur_y, 6'd0) +: SCR_W];
    // Finish on the last requested row or on the bottom screen row (vertical clip).
    assign w_last    = (r_row + 4'd1 == r_n) || (w_cur_y == 5'(SCR_H - 1));

    chip8_sprite_row_xor u_row_xor (
        .i_row  (w_cur_row),
        .i_byte (bus.mem_data),
        .i_x0   (r_x0),
        .o_row  (w_new_row),
        .o_coll (w_row_coll)
    );

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_state    <= ST_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_n        <= '0;
            r_row      <= '0;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_coll     <= 1'b0;
            r_fb       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_start) begin
                        r_state <= ST_CLEAR;
                    end else if (bus.draw_start) begin
                        r_x0   <= bus.x_in[5:0];
                        r_y0   <= bus.y_in[4:0];
                        r_n    <= bus.n_in;
                        r_base <= bus.i_addr;
                        r_row  <= '0;
                        r_coll <= 1'b0;
                        if (bus.n_in == 4'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= bus.i_addr;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_fb    <= '0;
                    r_state <= ST_DONE;
                end
                ST_FETCH: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= ST_DRAW;
                end
                ST_DRAW: begin
                    r_fb[fb_idx(w_cur_y, 6'd0) +: SCR_W] <= w_new_row;
                    r_coll <= r_coll | w_row_coll;
                    r_row  <= r_row + 4'd1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_base + ADDR_W'(r_row) + ADDR_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy              = (r_state == ST_CLEAR) || (r_state == ST_FETCH) || (r_state == ST_DRAW);
    assign bus.done              = (r_state == ST_DONE);
    assign bus.mem_rd            = r_mem_rd;
    assign bus.mem_addr          = r_mem_addr;
    assign bus.collision         = r_coll;
    assign bus.flat_video_memory = r_fb;
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// tb_chip8_sprite_draw: directed bench with a pixel-level model and per-cycle output checks.
module tb_chip8_sprite_draw;
    import chip8_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic [11:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip8_sprite_draw_if #(.ADDR_W(12)) bus ();

    chip8_sprite_draw #(.ADDR_W(12)) dut (
        .SYS_CLK   (clk),
        .SYS_RST_N (rst_n),
        .bus       (bus)
    );

    logic [7:0] mem [4096];
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    logic [2047:0] m_fb = '0;
    logic          m_coll = 1'b0;
    exp_t          q[$];
    exp_t          e;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_fb(input string name, input logic [2047:0] exp);
        int first;
        checks++;
        if (bus.flat_video_memory !== exp) begin
            errors++;
            first = -1;
            for (int i = 2047; i >= 0; i--) if (bus.flat_video_memory[i] !== exp[i]) first = i;
            $display("FAIL %s: got %0d lit pixels expected %0d, first differing bit %0d at %0t",
                     name, $countones(bus.flat_video_memory), $countones(exp), first, $time);
        end
    endtask

    // Per-cycle compare: scheduled expectations while an operation runs, idle rules otherwise.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("done", 32'(bus.done), 32'(e.done));
            chk("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
            if (e.rd) chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            if (e.done) begin
                chk_fb("fb at done", m_fb);
                chk("collision at done", 32'(bus.collision), 32'(m_coll));
            end
        end else begin
            chk("idle busy", 32'(bus.busy), 0);
            chk("idle done", 32'(bus.done), 0);
            chk("idle mem_rd", 32'(bus.mem_rd), 0);
            chk_fb("idle fb", m_fb);
            chk("idle collision", 32'(bus.collision), 32'(m_coll));
        end
    end

    // Issues one command, updates the model and schedules the expected per-cycle outputs.
    // lat > 0: measure cycles from the accept edge to done. keep > 0: schedule only that many cycles.
    task automatic do_cmd(input logic clr, input logic drw, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] n, input logic [11:0] ia, input int lat, input int keep);
        exp_t       s[$];
        int         x0, y0, c, cyc;
        logic [7:0] b;
        @(negedge clk);
        #1;
        bus.clear_start = clr;
        bus.draw_start  = drw;
        bus.x_in        = x;
        bus.y_in        = y;
        bus.n_in        = n;
        bus.i_addr      = ia;
        if (clr) begin
            s.push_back(exp_t'{1'b1, 1'b0, 1'b0, 12'h0});
            m_fb = '0;
        end else begin
            x0 = int'(x) % SCR_W;
            y0 = int'(y) % SCR_H;
            m_coll = 1'b0;
            for (int r = 0; r < int'(n); r++) begin
                if (y0 + r >= SCR_H) break;
                b = mem[ia + 12'(r)];
                s.push_back(exp_t'{1'b1, 1'b0, 1'b1, ia + 12'(r)});
                s.push_back(exp_t'{1'b1, 1'b0, 1'b0, 12'h0});
                for (int k = 0; k < 8; k++) begin
                    c = x0 + k;
                    if (c < SCR_W && b[7-k]) begin
                        if (m_fb[(y0 + r) * SCR_W + c]) m_coll = 1'b1;
                        m_fb[(y0 + r) * SCR_W + c] = ~m_fb[(y0 + r) * SCR_W + c];
                    end
                end
            end
        end
        s.push_back(exp_t'{1'b0, 1'b1, 1'b0, 12'h0});
        if (keep > 0) while (s.size() > keep) void'(s.pop_back());
        @(posedge clk);
        q = s;
        #1;
        bus.clear_start = 1'b0;
        bus.draw_start  = 1'b0;
        if (lat > 0) begin
            cyc = 0;
            do begin
                @(negedge clk);
                #1;
                cyc++;
            end while (!bus.done && cyc < 60);
            chk("latency", 32'(cyc), 32'(lat));
        end
        cyc = 0;
        while (q.size() != 0 && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("schedule drained", 32'(q.size()), 0);
    endtask

    logic [2047:0] v;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        for (int i = 0; i < 4; i++) mem[12'h100 + 12'(i)] = 8'hFF;
        mem[12'h200] = 8'h80;
        bus.draw_start = 1'b0;
        bus.clear_start = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.n_in = '0;
        bus.i_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset mem_addr", 32'(bus.mem_addr), 0);
        #1 rst_n = 1'b1;

        do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 2, 0);
        chk("collision after first clear", 32'(bus.collision), 0);

        do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 11, 0);
        chk("glyph row0", 32'(bus.flat_video_memory[7:0]), 32'h0F);
        chk("glyph row1", 32'(bus.flat_video_memory[71:64]), 32'h09);
        chk("glyph pixel count", 32'($countones(bus.flat_video_memory)), 14);
        chk("glyph collision", 32'(bus.collision), 0);

        do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 11, 0);
        chk("redraw pixel count", 32'($countones(bus.flat_video_memory)), 0);
        chk("redraw collision", 32'(bus.collision), 1);

        do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 2, 0);
        chk("clear keeps collision", 32'(bus.collision), 1);

        do_cmd(1'b0, 1'b1, 8'd62, 8'd30, 4'd4, 12'h100, 5, 0);
        v = '0;
        v[30*64+62] = 1'b1; v[30*64+63] = 1'b1; v[31*64+62] = 1'b1; v[31*64+63] = 1'b1;
        chk_fb("corner clip", v);

        do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 2, 0);
        do_cmd(1'b0, 1'b1, 8'd70, 8'd33, 4'd1, 12'h200, 3, 0);
        v = '0;
        v[1*64+6] = 1'b1;
        chk_fb("coordinate wrap", v);

        do_cmd(1'b1, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 2, 0);
        chk("clear priority pixel count", 32'($countones(bus.flat_video_memory)), 0);

        do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 0, 5);
        chk("row2 fetch strobe", 32'(bus.mem_rd), 1);
        chk("row2 fetch addr", 32'(bus.mem_addr), 32'h052);
        rst_n = 1'b0;
        m_fb = '0;
        m_coll = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 0);
        chk_fb("abort fb", '0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chip8_sprite_draw.md
Name: chip8_sprite_draw

Overview:
- Writer side of the CHIP-8 framebuffer: owns the 64x32 monochrome video memory and executes DXYN sprite draws and 00E0 clears on request from the CPU core.
- Fetches sprite bytes from system memory, XORs them into the framebuffer, and reports collision (VF).
- Exports the flat 2048-bit framebuffer consumed by the VGA scan-out block.

Parameters:
- SCR_W, 64, framebuffer width in pixels
- SCR_H, 32, framebuffer height in pixels
- ADDR_W, 12, system memory address width

Ports:
- SYS_CLK  in  1  system clock
- SYS_RST_N  in  1  asynchronous active-low reset
- draw_start  in  1  request a DXYN draw; sampled only in IDLE
- clear_start  in  1  request a 00E0 clear; sampled only in IDLE
- x_in  in  8  sprite X (Vx)
- y_in  in  8  sprite Y (Vy)
- n_in  in  4  sprite height in rows (N)
- i_addr  in  ADDR_W  sprite base address (I)
- mem_rd  out  1  read strobe to system memory
- mem_addr  out  ADDR_W  read address
- mem_data  in  8  read data; valid the cycle after mem_rd (1-cycle latency)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result of the last draw
- flat_video_memory  out  2048  framebuffer; bit index = row*64 + col, bit 0 = top-left

Behaviour:
- Reset (async, SYS_RST_N=0):
  - framebuffer all 0; busy, done, collision, mem_rd = 0; mem_addr = 0; state = IDLE.
  - Reset mid-draw aborts the draw; no done pulse.
- States: IDLE, CLEAR, FETCH, DRAW, DONE. busy=1 in CLEAR/FETCH/DRAW; done=1 only in DONE; DONE -> IDLE unconditionally.
- Accept (IDLE only):
  - clear_start=1 -> CLEAR. Has priority when asserted together with draw_start; that draw is dropped.
  - draw_start=1:
    - latch x0 = x_in mod 64, y0 = y_in mod 32, n = n_in, base = i_addr; row counter r = 0; collision <= 0.
    - go to FETCH, or straight to DONE if n=0 (no memory reads).
  - Starts asserted outside IDLE are ignored and not queued.
- CLEAR: one cycle; all 2048 bits <= 0; collision unchanged; next state DONE.
- FETCH:
  - mem_rd=1, mem_addr = (base + r) mod 2^ADDR_W; next state DRAW.
  - mem_rd=0 in every other state.
- DRAW:
  - byte = mem_data; sprite bit 7 (MSB) is the leftmost pixel at column x0, bit 0 at column x0+7.
  - For each bit b set, with column c = x0+b < 64: collision set if fb[(y0+r)*64+c] is 1 before the XOR; fb bit <= fb bit XOR 1.
  - Columns >= 64 are clipped, with no horizontal wrap.
  - r <= r+1. Next state is DONE if r+1 == n or y0+r+1 >= 32 (vertical clip, remaining rows skipped); else FETCH.
- Latency, counted from the accept edge as cycle 0:
  - draw of n unclipped rows: done high in cycle 2n+1.
  - clear: done high in cycle 2.
  - n=0: done high in cycle 1.
- collision:
  - sticky within a draw; valid when done is high; held until the next draw accept.
  - Clear does not modify it.
- flat_video_memory is registered state. Updates are visible the cycle after the DRAW/CLEAR edge; the scan-out tolerates mid-frame changes.

Decomposition:
- Shared package chip8_pkg:
  - SCR_W/SCR_H constants
  - framebuffer index function (row*64+col)
  - draw-engine state enum
- Sub-module chip8_sprite_row_xor: purely combinational.
  - Inputs: 64-bit row, 8-bit sprite byte, 6-bit x0.
  - Outputs: new 64-bit row and a row-collision flag, with clipping applied.
- The top level holds the FSM, counters, address generation and framebuffer register.

Test Plan:
- Reset, then clear_start -> busy for 1 cycle, done in cycle 2, all 2048 bits 0, collision 0.
- Draw x=0,y=0,n=5,I=0x050 with memory bytes F0,90,90,90,F0 ("0" glyph):
  - mem_addr 0x050..0x054, one per FETCH;
  - bits 0-3 set (row 0); bits 64 and 67 set (row 1);
  - done in cycle 11; collision 0.
- Repeat the identical draw -> all affected bits return to 0; collision 1.
- Draw x=62,y=30,n=4, bytes FF each:
  - only bits 30*64+62, 30*64+63, 31*64+62, 31*64+63 set;
  - two FETCHes only; done in cycle 5.
- Draw x=70 (wraps to 6), y=33 (wraps to 1), n=1, byte 80 -> only bit 1*64+6 set.
- draw_start and clear_start asserted together in IDLE -> clear executes, draw dropped, no mem_rd.
- SYS_RST_N pulsed low during FETCH of row 2 -> framebuffer 0, busy 0, no done pulse.
